// File: rtl/uart_pkg.sv
// Shared defaults and helpers for the UART baud/oversample tick generator.
// The fractional divisor (UART_BAUD_FRAC_EN) is configured in the users of this package.
package uart_pkg;

  localparam int DIV_W_DEF = 14;
  localparam int FRAC_W_DEF = 4;
  localparam int OVS_DEF = 16;
  localparam logic [13:0] DIV_RESET_DEF = 14'd20;

  // Integer divisor D for a target baud rate: one oversample period is D+1 clocks.
  function automatic int unsigned divisor_from_baud(input int unsigned clk_hz,
                                                    input int unsigned baud,
                                                    input int unsigned ovs);
    int unsigned period;
    period = (clk_hz + (baud * ovs) / 2) / (baud * ovs);
    return (period > 0) ? period - 1 : 0;
  endfunction

endpackage

// File: rtl/uart_baud_gen_if.sv
// Configuration/tick bundle between the bus-side registers (master) and the
// baud generator (slave).
interface uart_baud_gen_if
  import uart_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEF,
  parameter int FRAC_W = FRAC_W_DEF,
  parameter int OVS = OVS_DEF
);
  localparam int PH_W = $clog2(OVS);

  logic              count_en;
  logic [DIV_W-1:0]  div_int;
  logic [FRAC_W-1:0] div_frac;
  logic              div_load;
  logic              phase_clr;
  logic              os_tick;
  logic              baud_tick;
  logic [PH_W-1:0]   phase;
  logic              div_ack;

  modport master (
    output count_en, div_int, div_frac, div_load, phase_clr,
    input  os_tick, baud_tick, phase, div_ack
  );

  modport slave (
    input  count_en, div_int, div_frac, div_load, phase_clr,
    output os_tick, baud_tick, phase, div_ack
  );
endinterface

// File: rtl/uart_baud_gen_div_counter.sv
// Reload down-counter emitting the terminal pulse; with UART_BAUD_FRAC_EN defined
// it also carries the fractional accumulator that stretches a reload by one cycle.
module baud_div_counter
  import uart_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEF,
  parameter int FRAC_W = FRAC_W_DEF,
  parameter logic [DIV_W-1:0] DIV_RESET = DIV_W'(DIV_RESET_DEF)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en_i,
  input  logic              clr_i,
  input  logic              force_i,
  input  logic [DIV_W-1:0]  reload_int_i,
`ifdef UART_BAUD_FRAC_EN
  input  logic [FRAC_W-1:0] reload_frac_i,
`endif
  output logic              term_o
);

  // One extra bit so a carry reload of D+1 never wraps at the maximum divisor.
  logic [DIV_W:0] cnt_q, cnt_d;

`ifdef UART_BAUD_FRAC_EN
  logic [FRAC_W-1:0] acc_q, acc_d;
  logic              carry;
`endif

  assign term_o = en_i && !clr_i && (cnt_q == '0);

  always_comb begin
    cnt_d = cnt_q;
`ifdef UART_BAUD_FRAC_EN
    acc_d = acc_q;
    carry = 1'b0;
`endif
    if (clr_i) begin
      cnt_d = {1'b0, reload_int_i};
`ifdef UART_BAUD_FRAC_EN
      acc_d = '0;
`endif
    end else if (force_i) begin
      cnt_d = {1'b0, reload_int_i};
    end else if (en_i) begin
      if (cnt_q == '0) begin
`ifdef UART_BAUD_FRAC_EN
        {carry, acc_d} = {1'b0, acc_q} + {1'b0, reload_frac_i};
        cnt_d = {1'b0, reload_int_i} + {{DIV_W{1'b0}}, carry};
`else
        cnt_d = {1'b0, reload_int_i};
`endif
      end else begin
        cnt_d = cnt_q - {{DIV_W{1'b0}}, 1'b1};
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= {1'b0, DIV_RESET};
    end else begin
      cnt_q <= cnt_d;
    end
  end

`ifdef UART_BAUD_FRAC_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end
`endif

endmodule

// File: rtl/uart_baud_gen.sv
// Baud/oversample tick generator: divisor load handshake, bit-phase counter and
// registered tick outputs. Define UART_BAUD_FRAC_EN to enable the fractional divisor.
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int DIV_W = DIV_W_DEF,
  parameter int FRAC_W = FRAC_W_DEF,
  parameter int OVS = OVS_DEF,
  parameter logic [DIV_W-1:0] DIV_RESET = DIV_W'(DIV_RESET_DEF)
) (
  input logic           clk,
  input logic           rst,
  uart_baud_gen_if.slave bus
);

  localparam int PH_W = $clog2(OVS);

  logic             pending_q;
  logic [DIV_W-1:0] shadow_int_q, active_int_q, reload_int;
  logic [PH_W-1:0]  phase_q;
  logic             os_tick_q, baud_tick_q, div_ack_q;
  logic             term, apply, force_load;

`ifdef UART_BAUD_FRAC_EN
  logic [FRAC_W-1:0] shadow_frac_q, active_frac_q, reload_frac;
  assign reload_frac = pending_q ? shadow_frac_q : active_frac_q;
`endif

  // A pending divisor takes effect at any point the counter reloads.
  assign apply      = pending_q && (bus.phase_clr || !bus.count_en || term);
  assign force_load = pending_q && !bus.count_en && !bus.phase_clr;
  assign reload_int = pending_q ? shadow_int_q : active_int_q;

  baud_div_counter #(
    .DIV_W     (DIV_W),
    .FRAC_W    (FRAC_W),
    .DIV_RESET (DIV_RESET)
  ) u_counter (
    .clk          (clk),
    .rst          (rst),
    .en_i         (bus.count_en),
    .clr_i        (bus.phase_clr),
    .force_i      (force_load),
    .reload_int_i (reload_int),
`ifdef UART_BAUD_FRAC_EN
    .reload_frac_i(reload_frac),
`endif
    .term_o       (term)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_q    <= 1'b0;
      shadow_int_q <= DIV_RESET;
      active_int_q <= DIV_RESET;
      div_ack_q    <= 1'b0;
    end else begin
      if (apply) begin
        active_int_q <= shadow_int_q;
      end
      // A request arriving on an apply edge stays pending for the next reload.
      if (bus.div_load) begin
        shadow_int_q <= bus.div_int;
        pending_q    <= 1'b1;
      end else if (apply) begin
        pending_q <= 1'b0;
      end
      div_ack_q <= apply;
    end
  end

`ifdef UART_BAUD_FRAC_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shadow_frac_q <= '0;
      active_frac_q <= '0;
    end else begin
      if (apply) begin
        active_frac_q <= shadow_frac_q;
      end
      if (bus.div_load) begin
        shadow_frac_q <= bus.div_frac;
      end
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phase_q     <= '0;
      os_tick_q   <= 1'b0;
      baud_tick_q <= 1'b0;
    end else if (bus.phase_clr) begin
      phase_q     <= '0;
      os_tick_q   <= 1'b0;
      baud_tick_q <= 1'b0;
    end else if (term) begin
      phase_q     <= phase_q + PH_W'(1);
      os_tick_q   <= 1'b1;
      baud_tick_q <= (phase_q == PH_W'(OVS - 1));
    end else begin
      os_tick_q   <= 1'b0;
      baud_tick_q <= 1'b0;
    end
  end

  assign bus.os_tick   = os_tick_q;
  assign bus.baud_tick = baud_tick_q;
  assign bus.phase     = phase_q;
  assign bus.div_ack   = div_ack_q;

endmodule

// File: doc/uart_baud_gen.md
# uart_baud_gen

Parametrised baud/oversample tick generator for the UART transmitter and receiver paths. It extends the fixed single-rate baud generator with four additions: a runtime-loadable divisor with a load/acknowledge handshake, an oversample tick plus a bit-phase counter for the receiver, a phase-realign input for start-bit alignment, and an optional fractional divisor. It sits between the bus-side configuration registers and the TX/RX bit engines.

## Interface
- DIV_W, 14: integer divisor width.
- FRAC_W, 4: fractional divisor width (used only with the macro).
- OVS, 16: oversample ticks per bit; power of two, ≥2.
- DIV_RESET, 14'd20: integer divisor after reset.
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- count_en  in  1  count enable; counters hold while low.
- div_int  in  DIV_W  new integer divisor D.
- div_frac  in  FRAC_W  new fractional divisor F.
- div_load  in  1  one-cycle request to latch div_int/div_frac.
- phase_clr  in  1  synchronous realign of counter, phase and accumulator.
- os_tick  out  1  one-cycle oversample tick.
- baud_tick  out  1  one-cycle bit tick.
- phase  out  $clog2(OVS)  current oversample phase within the bit.
- div_ack  out  1  one-cycle pulse when a loaded divisor becomes active.

## Operation
- Down-counter cnt is loaded with the active D and decrements on each enabled cycle.
- Terminal condition: cnt==0 while count_en=1.
  - cnt reloads with D.
  - os_tick pulses.
  - One oversample period is D+1 enabled cycles.
  - D=0 gives os_tick high on every enabled cycle.
- phase increments modulo OVS on every os_tick. baud_tick pulses together with the os_tick that wraps phase from OVS-1 to 0.
- Divisor load:
  - div_load copies div_int/div_frac into shadow registers and sets pending.
  - Pending is applied at the next terminal condition: the reload uses the new D and div_ack pulses.
  - If count_en=0, pending is applied on the next cycle instead: cnt=new D, phase unchanged.
  - A second div_load while pending overwrites the shadow (last wins); exactly one div_ack results.
- phase_clr:
  - Sets cnt=active D, phase=0, accumulator=0.
  - Suppresses any tick that cycle.
  - Applies a pending load in the same cycle (div_ack pulses).
  - Has priority over the terminal condition and over count_en=0.
- count_en low: cnt, phase and accumulator hold; os_tick, baud_tick and div_ack stay 0, except for an ack caused by a load apply.
- Simultaneous div_load and terminal condition: the terminal reload uses the old active value and the new request becomes pending.

## Timing
- All outputs are registered.
- Reset values: os_tick=0, baud_tick=0, div_ack=0, phase=0. Internally: cnt=DIV_RESET, active D=DIV_RESET, F=0, accumulator=0, pending=0.
- Tick latency: os_tick is high in the cycle after the clock edge at which the terminal condition is sampled. After reset with count_en=1 from the first edge, the first os_tick follows the (D+1)th edge.
- div_ack is high in the cycle following the apply edge.
- Asserting rst mid-operation clears all state immediately. Counting restarts from DIV_RESET after release.

## Configuration
- UART_BAUD_FRAC_EN defined:
  - A FRAC_W-bit accumulator adds F at every terminal reload.
  - On carry-out, the reload value is D+1, giving an oversample period of D+2.
  - Average period is D+1+F/2^FRAC_W.
- Undefined: div_frac is ignored, no accumulator is synthesised, and every period is D+1.

## Structure
- Shared package uart_pkg holds:
  - the DIV_W, FRAC_W, OVS and DIV_RESET defaults;
  - a divisor-from-baud-rate constant function.
- One sub-module, baud_div_counter, holds the reload down-counter and the fractional accumulator, and emits the terminal pulse.
- The top level holds the shadow/pending handshake, the phase counter and the output registers.

## Test plan
All scenarios use D=20, OVS=16, FRAC_W=4 unless stated.
- Reset, then count_en=1 -> os_tick every 21 cycles, first on the 21st enabled edge; baud_tick every 336 cycles; phase steps 0..15.
- count_en low for 5 cycles mid-period -> the next os_tick is delayed exactly 5 cycles; no tick while low.
- div_load with D=9 in mid-period -> div_ack at the end of the current 21-cycle period; subsequent os_tick every 10 cycles; two back-to-back loads (9 then 4) give one ack and 5-cycle periods.
- With UART_BAUD_FRAC_EN and F=8 -> oversample periods alternate 21/22 cycles; 16 os_ticks span 344 cycles. Without the macro -> 336 cycles, F ignored.
- phase_clr at phase=7 -> phase=0, no tick that cycle; next os_tick 21 cycles later; baud_tick 16 os_ticks later.
- rst asserted mid-count -> all outputs 0 immediately; after release, the first os_tick again on the 21st enabled edge; a pending load is discarded with no div_ack.
